branch_phase_ctrl: RTL and testbench

Phase sequencer and branch resolver for the multi-cycle core. It generates the 3-bit `phase` that steps every datapath block through one instruction. It latches ALU condition flags and resolves conditional jumps. It drives `j_flag`/`j_addr` to the program counter, which samples them during phase 5.

---
 rtl/branch_phase_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_branch_phase_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_phase_ctrl.sv
// branch_phase_ctrl
// Instruction phase sequencer and branch resolver for the multi-cycle core.
// A free-running 3-bit phase counter walks every datapath block through one
// instruction. ALU condition flags are latched in FLAG_PHASE. The conditional
// jump is resolved in BR_PHASE against those registered flags. The jump request
// and target are then held for the whole of LAST_PHASE so the program counter
// can sample them. A halt decoded in BR_PHASE is deferred to the end of the
// instruction, so a jump in the same instruction is still taken.
// All outputs are registered, so there is no combinational input-to-output path.

module branch_phase_ctrl #(
    parameter logic [2:0] LAST_PHASE = 3'd5,
    parameter logic [2:0] FLAG_PHASE = 3'd3,
    parameter logic [2:0] BR_PHASE   = 3'd4
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        run,
    input  logic        stall,
    input  logic        halt_req,
    input  logic [2:0]  br_type,
    input  logic [7:0]  disp,
    input  logic [15:0] pc_in,
    input  logic        flag_we,
    input  logic        alu_s,
    input  logic        alu_z,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic [2:0]  phase,
    output logic        j_flag,
    output logic [15:0] j_addr,
    output logic [3:0]  flags,
    output logic        running,
    output logic        halted
);

    // ------------------------------------------------------------------
    // Controller states
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Branch condition encodings carried by br_type
    localparam logic [2:0] BR_NEVER  = 3'b000;
    localparam logic [2:0] BR_ALWAYS = 3'b001;
    localparam logic [2:0] BR_EQ     = 3'b010;
    localparam logic [2:0] BR_LT     = 3'b011;
    localparam logic [2:0] BR_LE     = 3'b100;
    localparam logic [2:0] BR_NE     = 3'b101;
    localparam logic [2:0] BR_CS     = 3'b110;
    localparam logic [2:0] BR_RSVD   = 3'b111;

    // Bit positions inside the packed {S,Z,C,V} flag word
    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // ------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------
    state_t      state_q,        state_d;
    logic [2:0]  phase_q,        phase_d;
    logic        j_flag_q,       j_flag_d;
    logic [15:0] j_addr_q,       j_addr_d;
    logic [3:0]  flags_q,        flags_d;
    logic        halt_pending_q, halt_pending_d;

    // ------------------------------------------------------------------
    // Helper decode
    // ------------------------------------------------------------------
    logic        in_run;
    logic        at_flag_phase;
    logic        at_br_phase;
    logic        at_last_phase;
    logic [2:0]  phase_inc;
    logic [15:0] disp_sext;
    logic [15:0] target_addr;
    logic        cond_taken;
    logic        s_xor_v;

    assign in_run        = (state_q == ST_RUN);
    assign at_flag_phase = (phase_q == FLAG_PHASE);
    assign at_br_phase   = (phase_q == BR_PHASE);
    assign at_last_phase = (phase_q == LAST_PHASE);

    // Phase wraps back to 0 after the final phase of an instruction.
    assign phase_inc = at_last_phase ? 3'd0 : (phase_q + 3'd1);

    // Jump target: PC plus the sign-extended byte displacement. The sum is
    // 16 bits wide on purpose; wrap-around past 16'hFFFF is legal and the
    // carry-out is simply dropped.
    assign disp_sext   = {{8{disp[7]}}, disp};
    assign target_addr = pc_in + disp_sext;

    // Signed less-than uses the registered flags, never the live ALU outputs.
    assign s_xor_v = flags_q[FLAG_S] ^ flags_q[FLAG_V];

    // Condition evaluation for the selected branch type.
    always_comb begin
        cond_taken = 1'b0;
        case (br_type)
            BR_NEVER:  cond_taken = 1'b0;
            BR_ALWAYS: cond_taken = 1'b1;
            BR_EQ:     cond_taken = flags_q[FLAG_Z];
            BR_LT:     cond_taken = s_xor_v;
            BR_LE:     cond_taken = flags_q[FLAG_Z] | s_xor_v;
            BR_NE:     cond_taken = ~flags_q[FLAG_Z];
            BR_CS:     cond_taken = flags_q[FLAG_C];
            BR_RSVD:   cond_taken = 1'b0;
            default:   cond_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic: every register holds by default, and a stalled
    // cycle leaves all of them untouched. This includes the state
    // transition, so a run pulse that arrives during a stall is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        j_flag_d       = j_flag_q;
        j_addr_d       = j_addr_q;
        flags_d        = flags_q;
        halt_pending_d = halt_pending_q;

        if (!stall) begin
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    // Parked: the phase sits at 0 and no jump is requested.
                    // run starts a fresh instruction at phase 0.
                    phase_d  = 3'd0;
                    j_flag_d = 1'b0;
                    if (run) begin
                        state_d = ST_RUN;
                    end
                end

                ST_RUN: begin
                    phase_d = phase_inc;

                    // Capture the flags only when the instruction writes
                    // them. Otherwise they persist across instructions.
                    if (at_flag_phase && flag_we) begin
                        flags_d = {alu_s, alu_z, alu_c, alu_v};
                    end

                    // Resolve the branch and note any halt. The halt waits
                    // until the end of the instruction so a jump in the same
                    // instruction still reaches the PC.
                    if (at_br_phase) begin
                        j_addr_d       = target_addr;
                        j_flag_d       = cond_taken;
                        halt_pending_d = halt_req;
                    end

                    // Leaving the final phase: drop the jump request. The
                    // target address keeps its last value.
                    if (at_last_phase) begin
                        j_flag_d = 1'b0;
                        if (halt_pending_q) begin
                            state_d        = ST_HALT;
                            phase_d        = 3'd0;
                            halt_pending_d = 1'b0;
                        end
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a clean idle state.
                    state_d        = ST_IDLE;
                    phase_d        = 3'd0;
                    j_flag_d       = 1'b0;
                    halt_pending_d = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register with asynchronous reset. Reset clears every output
    // at once, even in the middle of an instruction.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            phase_q        <= 3'd0;
            j_flag_q       <= 1'b0;
            j_addr_q       <= 16'd0;
            flags_q        <= 4'd0;
            halt_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            j_flag_q       <= j_flag_d;
            j_addr_q       <= j_addr_d;
            flags_q        <= flags_d;
            halt_pending_q <= halt_pending_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from registers or from decoding the state
    // register.
    // ------------------------------------------------------------------
    assign phase   = phase_q;
    assign j_flag  = j_flag_q;
    assign j_addr  = j_addr_q;
    assign flags   = flags_q;
    assign running = (state_q == ST_RUN);
    assign halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_branch_phase_ctrl.sv
// Directed bench for branch_phase_ctrl. Inputs change 1 time unit after each
// rising edge, and outputs are checked at that same point.
`timescale 1ns/1ps

module tb_branch_phase_ctrl;

    logic        clock;
    logic        rst;
    logic        run;
    logic        stall;
    logic        halt_req;
    logic [2:0]  br_type;
    logic [7:0]  disp;
    logic [15:0] pc_in;
    logic        flag_we;
    logic        alu_s, alu_z, alu_c, alu_v;
    logic [2:0]  phase;
    logic        j_flag;
    logic [15:0] j_addr;
    logic [3:0]  flags;
    logic        running;
    logic        halted;

    int checks = 0;
    int errors = 0;

    branch_phase_ctrl dut (
        .clock    (clock),
        .rst      (rst),
        .run      (run),
        .stall    (stall),
        .halt_req (halt_req),
        .br_type  (br_type),
        .disp     (disp),
        .pc_in    (pc_in),
        .flag_we  (flag_we),
        .alu_s    (alu_s),
        .alu_z    (alu_z),
        .alu_c    (alu_c),
        .alu_v    (alu_v),
        .phase    (phase),
        .j_flag   (j_flag),
        .j_addr   (j_addr),
        .flags    (flags),
        .running  (running),
        .halted   (halted)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; stall = 1'b0; halt_req = 1'b0;
        br_type = 3'b000; disp = 8'h00; pc_in = 16'h0000; flag_we = 1'b0;
        alu_s = 1'b0; alu_z = 1'b0; alu_c = 1'b0; alu_v = 1'b0;

        // Reset state
        #12;
        chk("rst_phase",   16'(phase),   16'd0);
        chk("rst_jflag",   16'(j_flag),  16'd0);
        chk("rst_jaddr",   j_addr,       16'h0000);
        chk("rst_flags",   16'(flags),   16'd0);
        chk("rst_running", 16'(running), 16'd0);
        chk("rst_halted",  16'(halted),  16'd0);
        rst = 1'b0;

        // Start: after the edge that samples run, running=1 and phase=0
        step(1);
        run = 1'b1;
        step(1);
        run = 1'b0;
        chk("start_running", 16'(running), 16'd1);
        chk("start_phase",   16'(phase),   16'd0);

        // Free run: 1,2,3,4,5,0,1 with no jump while br_type is 000
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk("free_phase", 16'(phase),  16'((i + 1) % 6));
            chk("free_jflag", 16'(j_flag), 16'd0);
        end
        step(5);
        chk("free_wrap0", 16'(phase), 16'd0);

        // Taken BE
        step(3);
        chk("be_ph3", 16'(phase), 16'd3);
        flag_we = 1'b1; alu_z = 1'b1;
        step(1);
        flag_we = 1'b0; alu_z = 1'b0;
        chk("be_flags", 16'(flags), 16'h4);
        br_type = 3'b010; pc_in = 16'h0010; disp = 8'hFC;
        step(1);
        chk("be_ph5",   16'(phase),  16'd5);
        chk("be_jflag", 16'(j_flag), 16'd1);
        chk("be_jaddr", j_addr,      16'h000C);
        step(1);
        chk("be_clr_jflag", 16'(j_flag), 16'd0);
        chk("be_hold_addr", j_addr,      16'h000C);

        // Not-taken BLT: S=1 and V=1, so S^V=0
        step(3);
        flag_we = 1'b1; alu_s = 1'b1; alu_v = 1'b1;
        step(1);
        flag_we = 1'b0; alu_s = 1'b0; alu_v = 1'b0;
        chk("blt_flags", 16'(flags), 16'h9);
        br_type = 3'b011; pc_in = 16'h1234; disp = 8'h05;
        step(1);
        chk("blt_jflag", 16'(j_flag), 16'd0);
        chk("blt_jaddr", j_addr,      16'h1239);
        step(1);

        // Always-taken with address wrap-around
        step(4);
        br_type = 3'b001; pc_in = 16'hFFFF; disp = 8'h02;
        step(1);
        chk("wrap_jflag", 16'(j_flag), 16'd1);
        chk("wrap_jaddr", j_addr,      16'h0001);
        step(1);

        // Stall three cycles at phase 4 with BNE (Z=0, so taken)
        step(4);
        chk("stall_ph4", 16'(phase), 16'd4);
        br_type = 3'b101; pc_in = 16'h0100; disp = 8'h80;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("stall_phase", 16'(phase),  16'd4);
            chk("stall_jflag", 16'(j_flag), 16'd0);
            chk("stall_jaddr", j_addr,      16'h0001);
            chk("stall_flags", 16'(flags),  16'h9);
        end
        stall = 1'b0;
        step(1);
        chk("bne_ph5",   16'(phase),  16'd5);
        chk("bne_jflag", 16'(j_flag), 16'd1);
        chk("bne_jaddr", j_addr,      16'h0080);
        step(1);

        // Halt together with a jump
        step(4);
        halt_req = 1'b1; br_type = 3'b001; pc_in = 16'h0200; disp = 8'h10;
        step(1);
        halt_req = 1'b0;
        chk("hj_jflag",   16'(j_flag),  16'd1);
        chk("hj_jaddr",   j_addr,       16'h0210);
        chk("hj_running", 16'(running), 16'd1);
        chk("hj_halted0", 16'(halted),  16'd0);
        step(1);
        chk("halt_halted",  16'(halted),  16'd1);
        chk("halt_running", 16'(running), 16'd0);
        chk("halt_phase",   16'(phase),   16'd0);
        chk("halt_jflag",   16'(j_flag),  16'd0);
        step(2);
        chk("halt_hold_phase", 16'(phase), 16'd0);
        // A run pulse during a stall is lost
        stall = 1'b1; run = 1'b1;
        step(1);
        stall = 1'b0; run = 1'b0;
        chk("stall_run_lost", 16'(halted), 16'd1);
        // Resume
        run = 1'b1;
        step(1);
        run = 1'b0;
        chk("resume_running", 16'(running), 16'd1);
        chk("resume_halted",  16'(halted),  16'd0);
        chk("resume_phase0",  16'(phase),   16'd0);
        step(1);
        chk("resume_phase1", 16'(phase), 16'd1);

        // Asynchronous reset in phase 5 while j_flag=1
        step(2);
        flag_we = 1'b1; alu_z = 1'b1;
        step(1);
        flag_we = 1'b0; alu_z = 1'b0;
        br_type = 3'b010; pc_in = 16'h0300; disp = 8'h01;
        step(1);
        chk("ar_pre_phase", 16'(phase),  16'd5);
        chk("ar_pre_jflag", 16'(j_flag), 16'd1);
        chk("ar_pre_jaddr", j_addr,      16'h0301);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_phase",   16'(phase),   16'd0);
        chk("ar_jflag",   16'(j_flag),  16'd0);
        chk("ar_jaddr",   j_addr,       16'h0000);
        chk("ar_flags",   16'(flags),   16'd0);
        chk("ar_running", 16'(running), 16'd0);
        chk("ar_halted",  16'(halted),  16'd0);
        step(1);
        rst = 1'b0;
        step(1);
        chk("ar_idle_running", 16'(running), 16'd0);
        chk("ar_idle_phase",   16'(phase),   16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
